// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO block: configuration word widths, field offsets
// and the snapshot channel state encoding.
package gpio_pkg;

    localparam int CONF0_W = 24;
    localparam int CONF1_W = 17;

    localparam int C0_DIR  = 0;
    localparam int C0_IEN  = 8;
    localparam int C0_MODE = 16;

    localparam int C1_POL    = 0;
    localparam int C1_BOTH   = 8;
    localparam int C1_AGG_EN = 16;

    typedef enum logic [1:0] {
        DOUT_IDLE,
        DOUT_REQ,
        DOUT_WAIT
    } dout_state_e;

endpackage

// File: rtl/gpio_if.sv
// Host-side handshake bundle of the GPIO block; every req/ack here belongs to a
// foreign clock domain and is resynchronised inside the block.
interface gpio_if import gpio_pkg::*; #(
    parameter int PORT_NUM = 8
);

    logic                async_din_req;
    logic                async_din_ack;
    logic [PORT_NUM-1:0] async_din;

    logic                async_dout_req;
    logic                async_dout_ack;
    logic [PORT_NUM-1:0] async_dout;

    logic [PORT_NUM:0]   async_ir_req;
    logic [PORT_NUM:0]   async_ir_ack;

    logic                async_conf_0_req;
    logic                async_conf_0_ack;
    logic [CONF0_W-1:0]  async_conf_0;

    logic                async_conf_1_req;
    logic                async_conf_1_ack;
    logic [CONF1_W-1:0]  async_conf_1;

    modport master (
        output async_din_req, async_din, async_dout_ack, async_ir_ack,
        output async_conf_0_req, async_conf_0, async_conf_1_req, async_conf_1,
        input  async_din_ack, async_dout_req, async_dout, async_ir_req,
        input  async_conf_0_ack, async_conf_1_ack
    );

    modport slave (
        input  async_din_req, async_din, async_dout_ack, async_ir_ack,
        input  async_conf_0_req, async_conf_0, async_conf_1_req, async_conf_1,
        output async_din_ack, async_dout_req, async_dout, async_ir_req,
        output async_conf_0_ack, async_conf_1_ack
    );

endinterface

// File: rtl/gpio_hs_rx.sv
// Inbound four-phase receiver: synchronises req, captures the data bus once per
// request and returns ack in the local clock domain.
module gpio_hs_rx #(
    parameter int SYNC_STAGE = 2,
    parameter int WIDTH      = 8
) (
    input  logic             clock_fast,
    input  logic             reset,
    input  logic             req_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ack_o,
    output logic [WIDTH-1:0] data_o
);

    logic [SYNC_STAGE-1:0] sync_q;
    logic                  req_s;
    logic                  ack_q, ack_d;
    logic [WIDTH-1:0]      data_q, data_d;

    assign req_s = sync_q[SYNC_STAGE-1];

    always_ff @(posedge clock_fast) begin
        if (reset) begin
            sync_q <= '0;
            ack_q  <= 1'b0;
            data_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGE-2:0], req_i};
            ack_q  <= ack_d;
            data_q <= data_d;
        end
    end

    // The data bus is held stable by the sender from req rise until ack rise,
    // so it is safe to sample it directly once the synchronised req arrives.
    always_comb begin
        ack_d  = ack_q;
        data_d = data_q;
        if (req_s && !ack_q) begin
            data_d = data_i;
            ack_d  = 1'b1;
        end else if (!req_s && ack_q) begin
            ack_d = 1'b0;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = data_q;

endmodule

// File: rtl/gpio_top.sv
// GPIO block: tristate pins, host write/config receivers, pin snapshot channel
// and per-pin plus aggregate interrupt handshakes.
module gpio_top import gpio_pkg::*; #(
    parameter int PORT_NUM   = 8,
    parameter int SYNC_STAGE = 2
) (
    input  logic                clock_fast,
    input  logic                reset,
    inout  wire  [PORT_NUM-1:0] io,
    gpio_if.slave               bus
);

    localparam int IRW = PORT_NUM + 1;

    logic [PORT_NUM-1:0] out_q;
    logic [CONF0_W-1:0]  conf0_q;
    logic [CONF1_W-1:0]  conf1_q;

    gpio_hs_rx #(.SYNC_STAGE(SYNC_STAGE), .WIDTH(PORT_NUM)) u_din (
        .clock_fast (clock_fast),
        .reset      (reset),
        .req_i      (bus.async_din_req),
        .data_i     (bus.async_din),
        .ack_o      (bus.async_din_ack),
        .data_o     (out_q)
    );

    gpio_hs_rx #(.SYNC_STAGE(SYNC_STAGE), .WIDTH(CONF0_W)) u_conf0 (
        .clock_fast (clock_fast),
        .reset      (reset),
        .req_i      (bus.async_conf_0_req),
        .data_i     (bus.async_conf_0),
        .ack_o      (bus.async_conf_0_ack),
        .data_o     (conf0_q)
    );

    gpio_hs_rx #(.SYNC_STAGE(SYNC_STAGE), .WIDTH(CONF1_W)) u_conf1 (
        .clock_fast (clock_fast),
        .reset      (reset),
        .req_i      (bus.async_conf_1_req),
        .data_i     (bus.async_conf_1),
        .ack_o      (bus.async_conf_1_ack),
        .data_o     (conf1_q)
    );

    logic [PORT_NUM-1:0] dir, ien, mode, pol, both;
    logic                agg_en;

    assign dir    = conf0_q[C0_DIR  +: PORT_NUM];
    assign ien    = conf0_q[C0_IEN  +: PORT_NUM];
    assign mode   = conf0_q[C0_MODE +: PORT_NUM];
    assign pol    = conf1_q[C1_POL  +: PORT_NUM];
    assign both   = conf1_q[C1_BOTH +: PORT_NUM];
    assign agg_en = conf1_q[C1_AGG_EN];

    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_pin_drive
            assign io[gi] = dir[gi] ? 1'bz : out_q[gi];
        end
    endgenerate

    logic [PORT_NUM-1:0]   pin_sync_q [SYNC_STAGE];
    logic [PORT_NUM-1:0]   pin_s;
    logic [PORT_NUM-1:0]   pin_p_q;
    logic [IRW-1:0]        ir_ack_sync_q [SYNC_STAGE];
    logic [IRW-1:0]        ir_ack_s;
    logic [SYNC_STAGE-1:0] dout_ack_sync_q;
    logic                  dout_ack_s;

    assign pin_s      = pin_sync_q[SYNC_STAGE-1];
    assign ir_ack_s   = ir_ack_sync_q[SYNC_STAGE-1];
    assign dout_ack_s = dout_ack_sync_q[SYNC_STAGE-1];

    always_ff @(posedge clock_fast) begin
        if (reset) begin
            pin_p_q         <= '0;
            dout_ack_sync_q <= '0;
            for (int k = 0; k < SYNC_STAGE; k++) begin
                pin_sync_q[k]    <= '0;
                ir_ack_sync_q[k] <= '0;
            end
        end else begin
            pin_sync_q[0]    <= io;
            ir_ack_sync_q[0] <= bus.async_ir_ack;
            for (int k = 1; k < SYNC_STAGE; k++) begin
                pin_sync_q[k]    <= pin_sync_q[k-1];
                ir_ack_sync_q[k] <= ir_ack_sync_q[k-1];
            end
            pin_p_q         <= pin_s;
            dout_ack_sync_q <= {dout_ack_sync_q[SYNC_STAGE-2:0], bus.async_dout_ack};
        end
    end

    // Snapshot channel: output pins are masked to 0 so only inputs are reported.
    dout_state_e         dout_state_q, dout_state_d;
    logic [PORT_NUM-1:0] dout_q, dout_d;
    logic                dout_req_q, dout_req_d;
    logic [PORT_NUM-1:0] pin_masked;

    assign pin_masked = pin_s & dir;

    always_ff @(posedge clock_fast) begin
        if (reset) begin
            dout_state_q <= DOUT_IDLE;
            dout_q       <= '0;
            dout_req_q   <= 1'b0;
        end else begin
            dout_state_q <= dout_state_d;
            dout_q       <= dout_d;
            dout_req_q   <= dout_req_d;
        end
    end

    always_comb begin
        dout_state_d = dout_state_q;
        dout_d       = dout_q;
        dout_req_d   = dout_req_q;
        case (dout_state_q)
            DOUT_IDLE: begin
                if (pin_masked != dout_q) begin
                    dout_d       = pin_masked;
                    dout_req_d   = 1'b1;
                    dout_state_d = DOUT_REQ;
                end
            end
            DOUT_REQ: begin
                if (dout_ack_s) begin
                    dout_req_d   = 1'b0;
                    dout_state_d = DOUT_WAIT;
                end
            end
            DOUT_WAIT: begin
                if (!dout_ack_s) begin
                    dout_state_d = DOUT_IDLE;
                end
            end
            default: dout_state_d = DOUT_IDLE;
        endcase
    end

    assign bus.async_dout_req = dout_req_q;
    assign bus.async_dout     = dout_q;

    // Interrupt sources: bit PORT_NUM is the aggregate of all pending pin bits.
    logic [IRW-1:0] act, cond;
    logic [IRW-1:0] pend_q, pend_d;
    logic [IRW-1:0] busy_q, busy_d;
    logic [IRW-1:0] ir_req_q, ir_req_d;

    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_irq_cond
            logic hit;
            assign hit = !mode[gi] ? (pin_s[gi] == pol[gi]) :
                         both[gi]  ? (pin_s[gi] ^ pin_p_q[gi]) :
                         pol[gi]   ? (pin_s[gi] & ~pin_p_q[gi]) :
                                     (~pin_s[gi] & pin_p_q[gi]);
            assign act[gi]  = dir[gi] & ien[gi];
            assign cond[gi] = act[gi] & hit;
        end
    endgenerate

    assign act[PORT_NUM]  = agg_en;
    assign cond[PORT_NUM] = agg_en & (|pend_q[PORT_NUM-1:0]);

    always_ff @(posedge clock_fast) begin
        if (reset) begin
            pend_q   <= '0;
            busy_q   <= '0;
            ir_req_q <= '0;
        end else begin
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            ir_req_q <= ir_req_d;
        end
    end

    // busy spans ack-high until ack-low; conditions seen then are dropped, so
    // only a still-active level re-arms once the channel is free.
    always_comb begin
        pend_d   = pend_q;
        busy_d   = busy_q;
        ir_req_d = ir_req_q;
        for (int k = 0; k < IRW; k++) begin
            if (ir_req_q[k]) begin
                if (ir_ack_s[k]) begin
                    ir_req_d[k] = 1'b0;
                    pend_d[k]   = 1'b0;
                    busy_d[k]   = 1'b1;
                end
            end else if (busy_q[k]) begin
                if (!ir_ack_s[k]) begin
                    busy_d[k] = 1'b0;
                end
            end else if (!ir_ack_s[k]) begin
                if (cond[k]) begin
                    pend_d[k] = 1'b1;
                end
                if (pend_q[k] && act[k]) begin
                    ir_req_d[k] = 1'b1;
                end
            end
            if (!act[k]) begin
                pend_d[k] = 1'b0;
            end
        end
    end

    assign bus.async_ir_req = ir_req_q;

endmodule

// File: tb/tb_gpio_top.sv
// Self-checking bench for gpio_top: host handshakes, pin drive, snapshot
// reporting and interrupt handshakes against a behavioural model.
module tb_gpio_top;

    localparam int PORT_NUM   = 8;
    localparam int SYNC_STAGE = 2;
    localparam int IRW        = PORT_NUM + 1;

    logic clock_fast = 1'b0;
    logic reset      = 1'b1;
    wire  [PORT_NUM-1:0] io;
    logic [PORT_NUM-1:0] tb_oe  = '0;
    logic [PORT_NUM-1:0] tb_pin = '0;

    int total = 0;
    int bad   = 0;

    logic [23:0]         m_conf0 = '0;
    logic [16:0]         m_conf1 = '0;
    logic [PORT_NUM-1:0] m_out   = '0;

    logic [IRW-1:0]      ir_auto = '1;
    int                  ir_cnt [IRW];
    logic [PORT_NUM-1:0] dout_seen [$];

    always #5 clock_fast = ~clock_fast;

    gpio_if #(.PORT_NUM(PORT_NUM)) bus ();

    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_tb_pin
            assign io[gi] = tb_oe[gi] ? tb_pin[gi] : 1'bz;
        end
    endgenerate

    gpio_top #(.PORT_NUM(PORT_NUM), .SYNC_STAGE(SYNC_STAGE)) dut (
        .clock_fast (clock_fast),
        .reset      (reset),
        .io         (io),
        .bus        (bus.slave)
    );

    // Host-side responder for the outbound channels.
    always @(negedge clock_fast) begin
        if (reset) begin
            bus.async_dout_ack = 1'b0;
            bus.async_ir_ack   = '0;
        end else begin
            if (bus.async_dout_req && !bus.async_dout_ack) begin
                dout_seen.push_back(bus.async_dout);
                bus.async_dout_ack = 1'b1;
            end else if (!bus.async_dout_req && bus.async_dout_ack) begin
                bus.async_dout_ack = 1'b0;
            end
            for (int k = 0; k < IRW; k++) begin
                if (ir_auto[k] && bus.async_ir_req[k] && !bus.async_ir_ack[k]) begin
                    bus.async_ir_ack[k] = 1'b1;
                    ir_cnt[k]++;
                end else if (!bus.async_ir_req[k] && bus.async_ir_ack[k]) begin
                    bus.async_ir_ack[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock_fast);
    endtask

    function automatic logic ack_of(input int ch);
        case (ch)
            0:       return bus.async_din_ack;
            1:       return bus.async_conf_0_ack;
            default: return bus.async_conf_1_ack;
        endcase
    endfunction

    function automatic logic [PORT_NUM-1:0] exp_io();
        return (m_conf0[7:0] & tb_pin) | (~m_conf0[7:0] & m_out);
    endfunction

    task automatic set_pins(input logic [PORT_NUM-1:0] v);
        tb_pin = v;
        tb_oe  = m_conf0[7:0];
    endtask

    // ch: 0 = din, 1 = conf_0, 2 = conf_1
    task automatic host_write(input int ch, input logic [23:0] data,
                              output int rise_lat, output int fall_lat);
        case (ch)
            0:       begin bus.async_din    = data[PORT_NUM-1:0]; bus.async_din_req    = 1'b1; end
            1:       begin bus.async_conf_0 = data;               bus.async_conf_0_req = 1'b1; end
            default: begin bus.async_conf_1 = data[16:0];         bus.async_conf_1_req = 1'b1; end
        endcase
        rise_lat = 0;
        while (!ack_of(ch) && rise_lat < 40) begin
            @(negedge clock_fast);
            rise_lat++;
        end
        total++;
        if (!ack_of(ch)) begin
            bad++;
            $display("FAIL hs_ack_rise ch=%0d got=0 want=1 within 40 clocks", ch);
        end
        case (ch)
            0:       m_out   = data[PORT_NUM-1:0];
            1:       m_conf0 = data;
            default: m_conf1 = data[16:0];
        endcase
        case (ch)
            0:       bus.async_din_req    = 1'b0;
            1:       bus.async_conf_0_req = 1'b0;
            default: bus.async_conf_1_req = 1'b0;
        endcase
        fall_lat = 0;
        while (ack_of(ch) && fall_lat < 40) begin
            @(negedge clock_fast);
            fall_lat++;
        end
        total++;
        if (ack_of(ch)) begin
            bad++;
            $display("FAIL hs_ack_fall ch=%0d got=1 want=0 within 40 clocks", ch);
        end
        $display("write ch=%0d data=%06h rise=%0d fall=%0d", ch, data, rise_lat, fall_lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clk(4);
        total++; if (bus.async_din_ack !== 1'b0) begin bad++; $display("FAIL reset_din_ack got=%b want=0", bus.async_din_ack); end
        total++; if (bus.async_conf_0_ack !== 1'b0) begin bad++; $display("FAIL reset_conf0_ack got=%b want=0", bus.async_conf_0_ack); end
        total++; if (bus.async_conf_1_ack !== 1'b0) begin bad++; $display("FAIL reset_conf1_ack got=%b want=0", bus.async_conf_1_ack); end
        total++; if (bus.async_dout_req !== 1'b0) begin bad++; $display("FAIL reset_dout_req got=%b want=0", bus.async_dout_req); end
        total++; if (bus.async_dout !== '0) begin bad++; $display("FAIL reset_dout got=%h want=00", bus.async_dout); end
        total++; if (bus.async_ir_req !== '0) begin bad++; $display("FAIL reset_ir_req got=%h want=000", bus.async_ir_req); end
        total++; if (io !== '0) begin bad++; $display("FAIL reset_io got=%h want=00", io); end
        reset = 1'b0;
        wait_clk(2);
        $display("reset released io=%h", io);
    endtask

    task automatic test_conf();
        int r, f;
        host_write(1, 24'h003CF0, r, f);
        total++; if (r != SYNC_STAGE + 1) begin bad++; $display("FAIL conf0_ack_rise_lat got=%0d want=%0d", r, SYNC_STAGE + 1); end
        total++; if (f != SYNC_STAGE + 1) begin bad++; $display("FAIL conf0_ack_fall_lat got=%0d want=%0d", f, SYNC_STAGE + 1); end
        host_write(2, 24'h000000, r, f);
        total++; if (r != SYNC_STAGE + 1) begin bad++; $display("FAIL conf1_ack_rise_lat got=%0d want=%0d", r, SYNC_STAGE + 1); end
        set_pins({4'($urandom_range(1, 15)), 4'h0});
        wait_clk(6);
        total++; if (io !== exp_io()) begin bad++; $display("FAIL conf_pin_drive got=%h want=%h", io, exp_io()); end
    endtask

    task automatic test_din();
        int r, f;
        logic [PORT_NUM-1:0] d;
        host_write(0, 24'h0000A5, r, f);
        total++; if (io[3:0] !== 4'h5) begin bad++; $display("FAIL din_a5_io got=%h want=5", io[3:0]); end
        total++; if (f != SYNC_STAGE + 1) begin bad++; $display("FAIL din_ack_fall_lat got=%0d want=%0d", f, SYNC_STAGE + 1); end
        for (int n = 0; n < 4; n++) begin
            d = 8'($urandom);
            host_write(0, {16'h0, d}, r, f);
            wait_clk(1);
            total++; if (io !== exp_io()) begin bad++; $display("FAIL din_rand_io got=%h want=%h", io, exp_io()); end
        end
    endtask

    task automatic test_dout();
        logic [PORT_NUM-1:0] last, masked, v;
        logic [PORT_NUM-1:0] exp_q [$];
        int base, got_n;
        wait_clk(20);
        base = dout_seen.size();
        last = tb_pin & m_conf0[7:0];
        for (int n = 0; n < 12; n++) begin
            v = ($urandom_range(0, 2) == 0) ? tb_pin : {4'($urandom), 4'h0};
            set_pins(v);
            wait_clk(30);
            masked = v & m_conf0[7:0];
            if (masked != last) exp_q.push_back(masked);
            last = masked;
            $display("pins=%h masked=%h reported=%0d", v, masked, dout_seen.size() - base);
        end
        got_n = dout_seen.size() - base;
        total++; if (got_n != exp_q.size()) begin bad++; $display("FAIL dout_count got=%0d want=%0d", got_n, exp_q.size()); end
        for (int n = 0; n < exp_q.size() && n < got_n; n++) begin
            total++;
            if (dout_seen[base + n] !== exp_q[n]) begin
                bad++;
                $display("FAIL dout_value idx=%0d got=%h want=%h", n, dout_seen[base + n], exp_q[n]);
            end
        end
    endtask

    task automatic test_level();
        int r, f;
        int c0 [IRW];
        ir_auto = '1;
        set_pins(8'hE0);
        host_write(1, 24'h00FFF0, r, f);
        set_pins(8'hE0);
        wait_clk(30);
        for (int k = 0; k < IRW; k++) c0[k] = ir_cnt[k];
        wait_clk(300);
        $display("level pin4 low: handshakes=%0d", ir_cnt[4] - c0[4]);
        total++; if (ir_cnt[4] - c0[4] < 5) begin bad++; $display("FAIL level_rearm got=%0d want>=5", ir_cnt[4] - c0[4]); end
        for (int k = 5; k < IRW; k++) begin
            total++;
            if (ir_cnt[k] != c0[k]) begin bad++; $display("FAIL level_quiet bit=%0d got=%0d want=0", k, ir_cnt[k] - c0[k]); end
        end
        set_pins(8'hF0);
        wait_clk(30);
        for (int k = 0; k < IRW; k++) c0[k] = ir_cnt[k];
        wait_clk(100);
        total++; if (ir_cnt[4] != c0[4]) begin bad++; $display("FAIL level_inactive got=%0d want=0", ir_cnt[4] - c0[4]); end
        total++; if (bus.async_ir_req !== '0) begin bad++; $display("FAIL level_idle_req got=%h want=000", bus.async_ir_req); end
    endtask

    task automatic test_edge();
        int r, f;
        int c0 [IRW];
        int e  [IRW];
        logic [3:0] prev, nv;
        logic evt;
        ir_auto = '1;
        host_write(2, 24'h005555, r, f);
        host_write(1, 24'hFFFF0F, r, f);
        set_pins({4'h0, 4'($urandom)});
        wait_clk(40);
        for (int k = 0; k < IRW; k++) begin c0[k] = ir_cnt[k]; e[k] = 0; end
        prev = tb_pin[3:0];
        for (int n = 0; n < 20; n++) begin
            nv = 4'($urandom);
            set_pins({4'h0, nv});
            for (int i = 0; i < 4; i++) begin
                if (m_conf1[8 + i]) evt = (prev[i] != nv[i]);
                else if (m_conf1[i]) evt = (!prev[i] && nv[i]);
                else evt = (prev[i] && !nv[i]);
                if (evt) e[i]++;
            end
            $display("edge step=%0d pins %h -> %h", n, prev, nv);
            prev = nv;
            wait_clk(40);
        end
        for (int k = 0; k < IRW; k++) begin
            total++;
            if (ir_cnt[k] - c0[k] != e[k]) begin
                bad++;
                $display("FAIL edge_count bit=%0d got=%0d want=%0d", k, ir_cnt[k] - c0[k], e[k]);
            end
        end
    endtask

    task automatic test_agg();
        int r, f;
        logic saw8;
        ir_auto = 9'h1FE;
        set_pins(tb_pin ^ 8'h01);
        saw8 = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock_fast);
            if (bus.async_ir_req[PORT_NUM]) saw8 = 1'b1;
        end
        total++; if (saw8 !== 1'b0) begin bad++; $display("FAIL agg_disabled got=1 want=0"); end
        total++; if (bus.async_ir_req[0] !== 1'b1) begin bad++; $display("FAIL agg_pin0_pending got=%b want=1", bus.async_ir_req[0]); end
        ir_auto[PORT_NUM] = 1'b0;
        host_write(2, 24'h013333, r, f);
        wait_clk(10);
        total++; if (bus.async_ir_req[PORT_NUM] !== 1'b1) begin bad++; $display("FAIL agg_enabled got=%b want=1", bus.async_ir_req[PORT_NUM]); end
        ir_auto = '1;
        wait_clk(60);
        total++; if (bus.async_ir_req !== '0) begin bad++; $display("FAIL agg_drained got=%h want=000", bus.async_ir_req); end
        $display("aggregate handshakes=%0d", ir_cnt[PORT_NUM]);
    endtask

    initial begin
        bus.async_din_req    = 1'b0;
        bus.async_din        = '0;
        bus.async_conf_0_req = 1'b0;
        bus.async_conf_0     = '0;
        bus.async_conf_1_req = 1'b0;
        bus.async_conf_1     = '0;
        test_reset();
        test_conf();
        test_din();
        test_dout();
        test_level();
        test_edge();
        test_agg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
